seven_seg_capture: RTL and testbench

Seven-segment pattern capture and encoder: samples an active-low 7-bit segment bus, filters it for stability, and converts each stable pattern back to the 5-bit display code used by the seven-segment mapping (0-9, a, b, C, d, e, F). It sits on the input side of the memory-tester game, reading patterns from a player keypad or display mirror. It hands codes to the game controller over a valid/ready interface.

---
 rtl/seven_seg_capture_if.sv | 21 ++
 rtl/seven_seg_capture.sv | 135 +++++++++++++
 tb/tb_seven_seg_capture.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_if.sv
// Segment capture bus: sampled segment pattern in, decoded code out.
// The slave modport is the capture block; the master side drives patterns and consumes codes.
interface seven_seg_capture_if;
    logic [6:0] seg_in;
    logic       seg_en;
    logic [4:0] code_out;
    logic       code_err;
    logic       code_valid;
    logic       code_ready;
    logic       overflow;

    modport master (
        output seg_in, seg_en, code_ready,
        input  code_out, code_err, code_valid, overflow
    );

    modport slave (
        input  seg_in, seg_en, code_ready,
        output code_out, code_err, code_valid, overflow
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Seven-segment capture: stability filter plus pattern-to-code encoder.
// Optional macro SEG_CAPTURE_DEDUP_EN suppresses repeats of the last emitted code.
module seven_seg_capture #(
    parameter int STABLE_CNT = 4
) (
    input logic               clk,
    input logic               rst,
    seven_seg_capture_if.slave bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);
    localparam logic [6:0] BLANK   = 7'b1111111;

    logic [6:0] last_pat;
    logic [7:0] run_cnt;
    logic       run_has;

    logic       same;
    logic       accept;
    logic       blank;
    logic       suppress;
    logic       emit;
    logic       load;
    logic [4:0] dec_code;
    logic       dec_err;

    logic [4:0] code_q;
    logic       err_q;
    logic       valid_q;
    logic       ovf_q;

    // Pattern-to-code lookup; unknown shapes map to the error code.
    always_comb begin
        dec_code = 5'b11111;
        dec_err  = 1'b0;
        case (bus.seg_in)
            7'b0000001: dec_code = 5'd0;
            7'b1001111: dec_code = 5'd1;
            7'b0010010: dec_code = 5'd2;
            7'b0000110: dec_code = 5'd3;
            7'b1001100: dec_code = 5'd4;
            7'b0100100: dec_code = 5'd5;
            7'b0100000: dec_code = 5'd6;
            7'b0001111: dec_code = 5'd7;
            7'b0000000: dec_code = 5'd8;
            7'b0000100: dec_code = 5'd9;
            7'b0000010: dec_code = 5'd10;
            7'b1100000: dec_code = 5'd11;
            7'b0110001: dec_code = 5'd12;
            7'b1000010: dec_code = 5'd13;
            7'b0010000: dec_code = 5'd14;
            7'b0111000: dec_code = 5'd15;
            default:    dec_err  = 1'b1;
        endcase
    end

    // Accept fires only on the sample that lands the run exactly on the threshold.
    always_comb begin
        same  = run_has && (bus.seg_in == last_pat);
        blank = (bus.seg_in == BLANK);
        if (!same)
            accept = bus.seg_en && (CNT_MAX == 8'd1);
        else
            accept = bus.seg_en && (run_cnt != CNT_MAX) &&
                     ((run_cnt + 8'd1) == CNT_MAX);
    end

    // Run tracker; disabled cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pat <= BLANK;
            run_cnt  <= 8'd0;
            run_has  <= 1'b0;
        end else if (bus.seg_en) begin
            if (!same) begin
                last_pat <= bus.seg_in;
                run_cnt  <= 8'd1;
                run_has  <= 1'b1;
            end else if (run_cnt < CNT_MAX) begin
                run_cnt  <= run_cnt + 8'd1;
            end
        end
    end

`ifdef SEG_CAPTURE_DEDUP_EN
    logic [4:0] dd_code;
    logic       dd_valid;

    always_comb suppress = dd_valid && (dd_code == dec_code);

    // Remember the last loaded code; an accepted blank forgets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dd_code  <= 5'd0;
            dd_valid <= 1'b0;
        end else if (accept && blank) begin
            dd_valid <= 1'b0;
        end else if (load) begin
            dd_code  <= dec_code;
            dd_valid <= 1'b1;
        end
    end
`else
    always_comb suppress = 1'b0;
`endif

    always_comb begin
        emit = accept && !blank && !suppress;
        load = emit && (!valid_q || bus.code_ready);
    end

    // One-entry output holding register with sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= 5'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            code_q  <= dec_code;
            err_q   <= dec_err;
            valid_q <= 1'b1;
        end else if (emit) begin
            ovf_q   <= 1'b1;
        end else if (valid_q && bus.code_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.code_out   = code_q;
    assign bus.code_err   = err_q;
    assign bus.code_valid = valid_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture at STABLE_CNT=4 and STABLE_CNT=1.
// Model works from the sample history; a negedge monitor checks handshakes.
module tb_seven_seg_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       seg_en;
    logic       code_ready;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seven_seg_capture_if b0 ();
    seven_seg_capture_if b1 ();

    assign b0.seg_in     = seg_in;
    assign b0.seg_en     = seg_en;
    assign b0.code_ready = code_ready;
    assign b1.seg_in     = seg_in;
    assign b1.seg_en     = seg_en;
    assign b1.code_ready = code_ready;

    seven_seg_capture #(.STABLE_CNT(4)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    seven_seg_capture #(.STABLE_CNT(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0010000, 7'b0111000
    };

    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 16; k++)
            if (tbl[k] == p) return {1'b0, 5'(k)};
        return 6'b111111;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model state, one slot per instance.
    int         nreq [2] = '{4, 1};
    logic [6:0] hist [2][512];
    int         hcnt [2];
    bit         mvalid [2];
    bit         movf [2];
    bit         dvalid [2];
    logic [4:0] dcode [2];
    logic [5:0] exp0 [$];
    logic [5:0] exp1 [$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            hcnt[i] = 0; mvalid[i] = 0; movf[i] = 0;
            dvalid[i] = 0; dcode[i] = 5'd0;
        end
    end

    // Model: accept when the trailing run of identical enabled samples is exactly N long.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                hcnt[i] = 0; mvalid[i] = 0; movf[i] = 0; dvalid[i] = 0;
                if (i == 0) exp0.delete(); else exp1.delete();
            end else begin
                bit acc;
                bit pushed;
                int len;
                logic [5:0] r;
                acc = 0;
                pushed = 0;
                if (seg_en) begin
                    hist[i][hcnt[i] % 512] = seg_in;
                    hcnt[i]++;
                    len = 0;
                    for (int k = hcnt[i] - 1; k >= 0 && k >= hcnt[i] - 300; k--) begin
                        if (hist[i][k % 512] != seg_in) break;
                        len++;
                    end
                    acc = (len == nreq[i]);
                end
                if (acc && seg_in == 7'b1111111) begin
                    dvalid[i] = 0;
                end else if (acc) begin
                    bit sup;
                    r = ref_decode(seg_in);
`ifdef SEG_CAPTURE_DEDUP_EN
                    sup = dvalid[i] && (dcode[i] == r[4:0]);
`else
                    sup = 0;
`endif
                    if (!sup) begin
                        if (!mvalid[i] || code_ready) begin
                            if (i == 0) exp0.push_back(r); else exp1.push_back(r);
                            mvalid[i] = 1;
                            dvalid[i] = 1;
                            dcode[i] = r[4:0];
                            pushed = 1;
                        end else begin
                            movf[i] = 1;
                        end
                    end
                end
                if (!pushed && mvalid[i] && code_ready) mvalid[i] = 0;
            end
        end
    end

    // Monitor: compare flags every cycle and pop a code at each handshake.
    always @(negedge clk) begin
        logic       v [2];
        logic       o [2];
        logic [5:0] d [2];
        logic [5:0] e;
        v[0] = b0.code_valid; o[0] = b0.overflow; d[0] = {b0.code_err, b0.code_out};
        v[1] = b1.code_valid; o[1] = b1.overflow; d[1] = {b1.code_err, b1.code_out};
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("valid%0d", i), int'(v[i]), int'(mvalid[i]));
                check($sformatf("overflow%0d", i), int'(o[i]), int'(movf[i]));
                if (v[i] && code_ready) begin
                    if ((i == 0 ? exp0.size() : exp1.size()) == 0) begin
                        check($sformatf("unexpected_code%0d", i), int'(d[i]), -1);
                    end else begin
                        e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                        check($sformatf("code%0d", i), int'(d[i]), int'(e));
                    end
                end
            end
        end
    end

    task automatic cyc(input logic [6:0] p, input logic en, input logic rdy);
        seg_in = p; seg_en = en; code_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [6:0] p, input int n, input logic rdy);
        for (int k = 0; k < n; k++) cyc(p, 1'b1, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(7'b1111111, 1'b0, 1'b0);
        cyc(7'b1111111, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; seg_in = 7'b1111111; seg_en = 1'b0; code_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("rst_valid0", int'(b0.code_valid), 0);
        check("rst_code0", int'({b0.code_err, b0.code_out}), 0);
        check("rst_ovf0", int'(b0.overflow), 0);
        check("rst_code1", int'({b1.code_err, b1.code_out}), 0);
        #1;

        run(7'b0010010, 6, 1'b1);
        run(7'b0010010, 2, 1'b1);
        run(7'b0000110, 4, 1'b1);
        run(7'b1111111, 1, 1'b1);
        run(7'b0000110, 2, 1'b1);
        for (int k = 0; k < 3; k++) cyc(7'b0000110, 1'b0, 1'b1);
        run(7'b0000110, 2, 1'b1);
        run(7'b1010101, 4, 1'b1);
        run(7'b1111111, 4, 1'b1);
        cyc(7'b1111111, 1'b0, 1'b1);

        run(7'b0001111, 4, 1'b0);
        run(7'b0000100, 4, 1'b0);
        cyc(7'b0000100, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_code0", int'(b0.code_out), 7);
        check("hold_ovf0", int'(b0.overflow), 1);
        #1;
        cyc(7'b0000100, 1'b0, 1'b1);
        @(negedge clk);
        check("drained0", int'(b0.code_valid), 0);
        #1;

        do_reset();
        run(7'b1001111, 1, 1'b1);
        run(7'b0010010, 1, 1'b1);
        rst = 1'b1;
        run(7'b0000110, 1, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid1", int'(b1.code_valid), 0);
        check("midrst_code1", int'({b1.code_err, b1.code_out}), 0);
        check("midrst_ovf1", int'(b1.overflow), 0);
        #1;

        run(7'b0100100, 4, 1'b1);
        run(7'b1111110, 1, 1'b1);
        run(7'b0100100, 4, 1'b1);
        run(7'b1111111, 4, 1'b1);
        run(7'b0100100, 4, 1'b1);

        for (int r = 0; r < 400; r++) begin
            logic [6:0] p;
            int sel;
            int len;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) p = 7'b1111111;
            else if (sel == 1) p = 7'($urandom);
            else p = tbl[$urandom_range(0, 15)];
            len = int'($urandom_range(1, 6));
            if ($urandom_range(0, 99) == 0) do_reset();
            for (int k = 0; k < len; k++)
                cyc(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        for (int k = 0; k < 4; k++) cyc(7'b1111111, 1'b0, 1'b1);
        @(negedge clk);
        check("left0", exp0.size(), 0);
        check("left1", exp1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
